// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
//   Bundles the requester handshake, baud-generator handshake and serial
//   output of the UART transmit scheduler.
//   req       : per-requester request level (held until ack)
//   data      : byte of requester i on [8i+7:8i]
//   ack       : one-cycle pulse, byte of requester i latched
//   grant_idx : requester whose frame is in flight (valid while busy)
//   busy      : frame in progress
//   done      : one-cycle pulse at the end of the stop bit
//   baud_en   : baud generator enable (tx_rx_start), high for the whole frame
//   baud_tick : one-cycle bit-boundary pulse from the baud generator
//   txd       : serial output, idle high
// Modports: master = requesters / baud generator side, slave = scheduler.
interface uart_tx_sched_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = 2
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] data;
   logic [NREQ-1:0]   ack;
   logic [IDX_W-1:0]  grant_idx;
   logic              busy;
   logic              done;
   logic              baud_en;
   logic              baud_tick;
   logic              txd;

   modport master (
      output req, data, baud_tick,
      input  ack, grant_idx, busy, done, baud_en, txd
   );

   modport slave (
      input  req, data, baud_tick,
      output ack, grant_idx, busy, done, baud_en, txd
   );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Round-robin scheduler sharing one 8N1 UART transmit line between NREQ
//   byte producers. Arbitrates in IDLE, latches the winner's byte, enables
//   the baud generator and shifts the frame out on each baud_tick.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_sched_if slave modport (req/data/ack, grant_idx, busy,
//           done, baud_en, baud_tick, txd); all outputs registered.
module uart_tx_sched #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_tx_sched_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t            r_state;
   logic [7:0]        r_shift;
   logic [2:0]        r_cnt;
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  r_grant;
   logic [NREQ-1:0]   r_ack;
   logic              r_busy;
   logic              r_done;
   logic              r_baud_en;
   logic              r_txd;

   logic              w_found;
   int unsigned       w_win_n;
   logic [IDX_W-1:0]  w_win;

   // Search starts at the pointer and wraps upward; the wrap is explicit so
   // non-power-of-two NREQ never yields an out-of-range index.
   always_comb begin
      int unsigned idx;
      w_found = 1'b0;
      w_win_n = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(r_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!w_found && bus.req[idx]) begin
            w_found = 1'b1;
            w_win_n = idx;
         end
      end
      w_win = IDX_W'(w_win_n);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_ptr     <= '0;
         r_grant   <= '0;
         r_ack     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_baud_en <= 1'b0;
         r_txd     <= 1'b1;
      end else begin
         r_ack  <= '0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_txd <= 1'b1;
               if (w_found) begin
                  r_shift        <= bus.data[8*w_win_n +: 8];
                  r_grant        <= w_win;
                  r_ack[w_win_n] <= 1'b1;
                  r_baud_en      <= 1'b1;
                  r_busy         <= 1'b1;
                  r_txd          <= 1'b0;
                  r_state        <= S_START;
               end
            end
            S_START: begin
               if (bus.baud_tick) begin
                  r_cnt   <= '0;
                  r_txd   <= r_shift[0];
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (bus.baud_tick) begin
                  r_shift <= r_shift >> 1;
                  r_cnt   <= r_cnt + 3'd1;
                  if (r_cnt == 3'd7) begin
                     r_txd   <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     // txd is registered, so present the next bit now
                     r_txd <= r_shift[1];
                  end
               end
            end
            S_STOP: begin
               if (bus.baud_tick) begin
                  r_baud_en <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_ptr     <= (r_grant == IDX_W'(NREQ - 1)) ? '0 : r_grant + 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ack       = r_ack;
   assign bus.grant_idx = r_grant;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.baud_en   = r_baud_en;
   assign bus.txd       = r_txd;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART serial transmit line between `NREQ` byte-producing requesters. It arbitrates pending requests, latches the winner's byte, and enables the baud-rate generator through `baud_en` (wired to its `tx_rx_start`). It then shifts out an 8N1 frame paced by the generator's one-cycle `baud_tick` (its `clk_baud`). The block sits between the on-chip byte sources and the baud generator / TX pin.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDX_W`, 2: width of `grant_idx`; must equal ceil(log2(NREQ)).
- `clk`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request level; held high until the matching `ack` bit.
- `data`  in  8*NREQ  byte of requester i on bits [8i+7:8i]; stable while `req[i]` is high.
- `ack`  out  NREQ  one-cycle pulse; byte of requester i latched.
- `grant_idx`  out  IDX_W  index of the requester whose frame is in flight; valid while `busy`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at the end of the stop bit.
- `baud_en`  out  1  drives baud generator `tx_rx_start`; high for the whole frame.
- `baud_tick`  in  1  one-cycle pulse from the baud generator marking each bit boundary.
- `txd`  out  1  serial output; idle high.

## Operation
- Frame format: start bit (0), D0..D7 LSB first, one stop bit (1).
- States:
  - IDLE: `txd`=1, `baud_en`=0, `busy`=0.
  - START: `txd`=0.
  - DATA: `txd`=shift[0], with 3-bit bit counter.
  - STOP: `txd`=1.
- IDLE -> START when any `req` bit is high. In the same edge:
  - latch the winner's byte into the shift register;
  - set `grant_idx`;
  - pulse `ack[winner]`;
  - set `baud_en`=1 and `busy`=1.
- START -> DATA on `baud_tick`, with bit counter=0.
- DATA on `baud_tick`: shift right by one and increment the counter. After the tick that ends D7 (counter=7), go to STOP.
- STOP -> IDLE on `baud_tick`. In the same edge: `baud_en`=0, `busy`=0, pulse `done`. Update the round-robin pointer to `grant_idx`+1 mod NREQ.
- Arbitration: priority starts at the pointer and wraps upward. The pointer resets to 0, so requester 0 has highest priority after reset.
- `baud_tick` is ignored in IDLE.
- `req` changes during a frame are ignored. They are only sampled in IDLE.
- A requester that drops `req` before winning is never acked. No byte is lost or duplicated.
- Out-of-range pointer values cannot occur for NREQ not a power of two: increment wraps explicitly at NREQ-1.

## Timing
- Reset values:
  - `txd`=1;
  - `baud_en`=0, `busy`=0, `done`=0;
  - `ack`=0, `grant_idx`=0;
  - pointer=0, state IDLE.
- Reset asserted mid-frame takes effect immediately. `txd` returns high and the frame is abandoned: no `done`, no re-send.
- All outputs are registered. No combinational path exists from inputs to outputs.
- `req` high at edge N (IDLE) gives, after edge N: `ack` pulse, `txd`=0, `baud_en`=1.
- A `baud_tick` sampled at edge N itself is ignored, since the state was IDLE.
- Each bit lasts from one sampled `baud_tick` to the next. A frame ends exactly on the 10th tick after START entry.
- Back-to-back: earliest next START is one edge after the `done` edge. There is always at least one IDLE cycle with `txd`=1 and `baud_en`=0, which restarts the baud generator counter.
- A `baud_tick` coincident with the STOP->IDLE edge is consumed by that transition only.

## Test plan
- Single request, bench ticks every 8 cycles. `req[2]`=1 with `data[23:16]`=8'hA5.
  - Required: `ack`=4'b0100 for one cycle; `grant_idx`=2.
  - `txd` sequence is 0,1,0,1,0,0,1,0,1,1, each held until the next tick.
  - `done` pulses once after the 10th tick; `baud_en` falls in the same cycle.
- Round-robin: `req`=4'b1111 held, re-asserted after each ack. Grant order is 0,1,2,3,0.
- Starvation / fairness: `req[1]` and `req[3]` continuous. Grants alternate 1,3,1,3.
- Reset in DATA after the 4th tick: `rst_n` low for 2 cycles.
  - `txd`=1 and `baud_en`=0 immediately; no `done`.
  - A re-raised `req[0]` then sends a full fresh frame.
- Ignored ticks and mid-frame requests:
  - Ticks in IDLE cause no activity.
  - `req[0]` rising mid-frame of requester 3 is served right after `done`, with exactly one IDLE cycle between frames.
- `data`=8'h00 and 8'hFF: `txd` holds 0 for 9 bit times, then 1 for the stop bit; for 8'hFF, 0 for one bit time, then 1 for 9.
